celera_softstart_ramp: RTL
==========================

# celera_softstart_ramp

Digital soft-start sequencer for the step-down converter. It generates the 6-bit ramp code `i[5:0]` and the `strobe_dac` / `global_dac` controls for the soft-start ladder DAC, and it consumes that DAC's `ok_dac` settle flag. It ramps the reference from 0 to full scale at a programmable step rate. On disable it ramps back down, and on fault it discharges the reference immediately. `ss_done` tells the regulator loop that soft-start is complete.

## Interface
- `CODE_W`, 6: DAC code width; full scale `CODE_MAX = 2**CODE_W-1`.
- `DIV_W`, 12: width of the step-rate divider.
- `PWRUP_MIN`, 4: minimum cycles in PWRUP before `ok_dac` is trusted.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  soft-start enable (synchronous, level).
- `fault`  in  1  converter fault (synchronous, level); highest priority.
- `step_div`  in  DIV_W  TICK length is `step_div+1` cycles per code step.
- `ok_dac`  in  1  DAC output settled; asynchronous analog flag.
- `i`  out  CODE_W  DAC code, registered.
- `strobe_dac`  out  1  one-cycle pulse coincident with every change of `i`.
- `global_dac`  out  1  DAC/buffer enable.
- `ss_done`  out  1  ramp at full scale and settled.
- `busy`  out  1  state is not IDLE.

## Operation
- `ok_dac` passes through a 2-flop synchronizer to give `ok_s`. It is used nowhere else.
- States: IDLE, PWRUP, TICK, SETTLE, DONE, RAMP_DN, FAULT.
- IDLE: `global_dac`=0, `i`=0. If `en`=1 and `fault`=0, go to PWRUP.
- PWRUP: `global_dac`=1. Exit to TICK when `pw_cnt>=PWRUP_MIN-1` and `ok_s`=1.
- TICK: divider counts 0..`step_div`. `step_div` is sampled on TICK entry and held for that step.
  - At terminal count in the up-direction: if `i<CODE_MAX`, then `i<=i+1`, `strobe_dac<=1`, go to SETTLE. If `i==CODE_MAX`, go to DONE with no strobe.
  - At terminal count in the down-direction: `i<=i-1` with strobe, then SETTLE. If `i==0`, go to IDLE.
- SETTLE: settle counter starts at 0. Exit when `cnt>=2` and `ok_s`=1, back to TICK in the current direction. If `ok_s` stays 0, remain in SETTLE indefinitely; `i` is held.
- DONE: `ss_done`=1, `i`=CODE_MAX, `global_dac`=1.
- `en` falls in PWRUP, TICK, SETTLE or DONE: the direction becomes down.
  - From DONE or TICK, go to RAMP_DN. RAMP_DN behaves as TICK in the down-direction.
  - From SETTLE, finish the settle first, then go to RAMP_DN.
  - From PWRUP with `i`=0, go directly to IDLE.
- `en` rises during RAMP_DN or a down-SETTLE: the direction becomes up and the ramp resumes from the current `i`. It never restarts from 0.
- `fault`=1 in any state other than IDLE: go to FAULT on the next edge.
  - `i<=0`. `strobe_dac` pulses once if `i` was nonzero.
  - `ss_done<=0`, `global_dac` stays 1.
- FAULT exits to IDLE once `fault`=0. It restarts only via a fresh `en` evaluation in IDLE.
- Simultaneous events: `fault` beats an `en` change, which beats the divider terminal count.

## Timing
- Reset values: `i`=0, `strobe_dac`=0, `global_dac`=0, `ss_done`=0, `busy`=0, state IDLE, all counters 0.
- `global_dac` rises 1 cycle after `en` is sampled high in IDLE. It falls 1 cycle after the ramp-down reaches IDLE.
- `strobe_dac` and `i` update on the same edge. `strobe_dac` is never asserted on consecutive cycles.
- With `ok_dac` held high, one step period is `step_div+1+3` cycles; the full ramp is 63 such periods.
- `ok_dac` has 2 cycles of latency to `ok_s`.
- `ss_done` asserts on the cycle DONE is entered. It deasserts on the edge that leaves DONE.

## Structure
- Package `celera_softstart_pkg`: state enum `ss_state_t`, direction enum, `CODE_MAX`, and the `PWRUP_MIN` default.
- Sub-module `celera_sync2` (2-flop reset-to-0 synchronizer) for `ok_dac`.
- Everything else is a single FSM plus the divider, settle and power-up counters.

## Test plan
- `step_div`=3, `ok_dac`=1, `en`↑ → strobes spaced exactly 7 cycles; `i` goes 1..63; `ss_done`=1 after the 63rd settle; 63 strobes total.
- Hold `ok_dac`=0 after the strobe for `i`=10 for 50 cycles → `i` stays 10 with no strobe; after `ok_dac`↑ the next strobe comes 2 + 1 + 4 cycles later.
- In DONE, drop `en` → 63 down-strobes, `i`=0, then IDLE; `global_dac`=0 one cycle later.
- At `i`=30 during the ramp-down, raise `en` → next strobe gives `i`=31, and the ramp continues to 63.
- Raise `fault` at `i`=40 → next edge `i`=0, a single strobe, `ss_done`=0, FAULT; release `fault` with `en`=1 → IDLE → PWRUP → ramp from 0.
- Pulse `rst_n` low mid-ramp at `i`=20 → all outputs reset immediately and asynchronously; after release, IDLE with `i`=0.

Source files
------------

// File: rtl/celera_softstart_pkg.sv
// Shared types and defaults for the soft-start reference sequencer.
package celera_softstart_pkg;

  localparam int CODE_W_DEF    = 6;
  localparam int DIV_W_DEF     = 12;
  localparam int PWRUP_MIN_DEF = 4;
  localparam int CODE_MAX      = (2 ** CODE_W_DEF) - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_TICK    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4,
    ST_RAMP_DN = 3'd5,
    ST_FAULT   = 3'd6
  } ss_state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } ss_dir_t;

endpackage

// File: rtl/celera_softstart_ramp_if.sv
// Ladder DAC control bundle: code, strobe and enable out, settle flag back.
interface celera_softstart_ramp_if #(
  parameter int CODE_W = 6
);
  logic [CODE_W-1:0] i;
  logic              strobe_dac;
  logic              global_dac;
  logic              ok_dac;

  modport master (output i, output strobe_dac, output global_dac, input ok_dac);
  modport slave  (input i, input strobe_dac, input global_dac, output ok_dac);
endinterface

// File: rtl/celera_sync2.sv
// Two-flop synchronizer, resets to 0, for a single asynchronous level.
module celera_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/celera_softstart_ramp.sv
// Soft-start sequencer: ramps the ladder DAC code up/down at a programmable
// rate, waiting for the DAC settle flag between steps; fault dumps to zero.
module celera_softstart_ramp
  import celera_softstart_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int PWRUP_MIN = PWRUP_MIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fault,
  input  logic [DIV_W-1:0]      step_div,
  celera_softstart_ramp_if.master dac,
  output logic                  ss_done,
  output logic                  busy
);
  localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CODE_W-1:0] CODE_TOP  = {CODE_W{1'b1}};
  localparam int                PW_W      = $clog2(PWRUP_MIN) + 1;
  localparam logic [PW_W-1:0]   PW_LAST   = PW_W'(PWRUP_MIN - 1);

  ss_state_t         state_r, state_nxt_s;
  ss_dir_t           dir_r, dir_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic              strobe_r, strobe_nxt_s;
  logic              gdac_r, done_r, busy_r;
  logic [DIV_W-1:0]  div_cnt_r, div_lim_r;
  logic [1:0]        set_cnt_r;
  logic [PW_W-1:0]   pw_cnt_r;
  logic              ok_s, div_term_s, div_load_s, in_step_s;

  celera_sync2 u_ok_sync (.clk(clk), .rst_n(rst_n), .d(dac.ok_dac), .q(ok_s));

  assign in_step_s  = (state_r == ST_TICK) || (state_r == ST_RAMP_DN);
  assign div_term_s = (div_cnt_r == div_lim_r);
  // Any fresh entry into a stepping state restarts the divider with a new rate
  assign div_load_s = ((state_nxt_s == ST_TICK) || (state_nxt_s == ST_RAMP_DN)) &&
                      (state_nxt_s != state_r);

  // Next-state and output decode; fault outranks en, en outranks the divider
  always_comb begin
    state_nxt_s  = state_r;
    dir_nxt_s    = dir_r;
    code_nxt_s   = code_r;
    strobe_nxt_s = 1'b0;
    if (fault && (state_r != ST_IDLE)) begin
      state_nxt_s  = ST_FAULT;
      code_nxt_s   = CODE_ZERO;
      strobe_nxt_s = (code_r != CODE_ZERO);
    end else begin
      case (state_r)
        ST_IDLE: begin
          code_nxt_s = CODE_ZERO;
          if (en && !fault) begin
            state_nxt_s = ST_PWRUP;
            dir_nxt_s   = DIR_UP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PWRUP: begin
          if (!en) begin
            state_nxt_s = ST_IDLE;
            dir_nxt_s   = DIR_DN;
          end else if ((pw_cnt_r >= PW_LAST) && ok_s) begin
            state_nxt_s = ST_TICK;
          end else begin
            state_nxt_s = ST_PWRUP;
          end
        end
        ST_TICK, ST_RAMP_DN: begin
          if ((dir_r == DIR_UP) != en) begin
            dir_nxt_s   = en ? DIR_UP : DIR_DN;
            state_nxt_s = en ? ST_TICK : ST_RAMP_DN;
          end else if (div_term_s) begin
            if (dir_r == DIR_UP) begin
              if (code_r != CODE_TOP) begin
                code_nxt_s   = code_r + CODE_ONE;
                strobe_nxt_s = 1'b1;
                state_nxt_s  = ST_SETTLE;
              end else begin
                state_nxt_s = ST_DONE;
              end
            end else begin
              if (code_r != CODE_ZERO) begin
                code_nxt_s   = code_r - CODE_ONE;
                strobe_nxt_s = 1'b1;
                state_nxt_s  = ST_SETTLE;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_SETTLE: begin
          // Direction tracks en during settle; the step only resumes once settled
          dir_nxt_s = en ? DIR_UP : DIR_DN;
          if ((set_cnt_r == 2'd2) && ok_s) begin
            state_nxt_s = en ? ST_TICK : ST_RAMP_DN;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_DONE: begin
          if (!en) begin
            dir_nxt_s   = DIR_DN;
            state_nxt_s = ST_RAMP_DN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        ST_FAULT: begin
          if (!fault) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          code_nxt_s  = CODE_ZERO;
        end
      endcase
    end
  end

  // State, direction and registered DAC-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      dir_r    <= DIR_UP;
      code_r   <= CODE_ZERO;
      strobe_r <= 1'b0;
      gdac_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      dir_r    <= dir_nxt_s;
      code_r   <= code_nxt_s;
      strobe_r <= strobe_nxt_s;
      gdac_r   <= (state_r != ST_IDLE);
      done_r   <= (state_nxt_s == ST_DONE);
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  // Step divider, settle and power-up counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      div_lim_r <= {DIV_W{1'b0}};
      set_cnt_r <= 2'd0;
      pw_cnt_r  <= {PW_W{1'b0}};
    end else begin
      if (div_load_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        div_lim_r <= step_div;
      end else if (in_step_s) begin
        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
        div_cnt_r <= {DIV_W{1'b0}};
      end
      if (state_r != ST_SETTLE) begin
        set_cnt_r <= 2'd0;
      end else if (set_cnt_r != 2'd2) begin
        set_cnt_r <= set_cnt_r + 2'd1;
      end else begin
        set_cnt_r <= set_cnt_r;
      end
      if (state_r != ST_PWRUP) begin
        pw_cnt_r <= {PW_W{1'b0}};
      end else if (pw_cnt_r != PW_LAST) begin
        pw_cnt_r <= pw_cnt_r + {{(PW_W-1){1'b0}}, 1'b1};
      end else begin
        pw_cnt_r <= pw_cnt_r;
      end
    end
  end

  assign dac.i          = code_r;
  assign dac.strobe_dac = strobe_r;
  assign dac.global_dac = gdac_r;
  assign ss_done        = done_r;
  assign busy           = busy_r;
endmodule
